// File: rtl/op2_arb_pkg.sv
// Shared types and reset constants for the two-requester fn2 arbiter.
package op2_arb_pkg;
   localparam int NREQ = 2;

   typedef logic       req_id_t;
   typedef logic [1:0] opnd_t;

   localparam req_id_t RST_LAST = 1'b1;
   localparam opnd_t   RST_C    = 2'b00;
endpackage

// File: rtl/fn2_unit.sv
// Purely combinational 2-bit function unit: c = fn2(a, b).
module fn2_unit
   import op2_arb_pkg::*;
(
   input  opnd_t a,
   input  opnd_t b,
   output opnd_t c
);
   logic p, q, r, s;

   always_comb begin
      p = a[1];
      q = a[0];
      r = b[1];
      s = b[0];
      c[1] = (~p & r & s) | (~p & q & r) | (p & ~r);
      c[0] = (p | q | s) & (q | r) & (~p | r);
   end
endmodule

// File: rtl/op2_arbiter.sv
// Round-robin arbiter sharing fn2_unit between two requesters; optional grant counters via OP2ARB_STATS_EN.
// Latency: handshake at edge N yields a registered result after edge N; one result per cycle.
// Backpressure: req_ready is low while a response is held with rsp_ready low.
module op2_arbiter
    import op2_arb_pkg::*;
#(
    parameter int CNT_W = 8
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  opnd_t           req_a0,
    input  opnd_t           req_b0,
    input  opnd_t           req_a1,
    input  opnd_t           req_b1,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output opnd_t           rsp_c,
    output req_id_t         rsp_id
`ifdef OP2ARB_STATS_EN
   ,output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
`endif
);
    req_id_t last;
    req_id_t cand;
    logic    adv;
    logic    hs;
    opnd_t   sel_a;
    opnd_t   sel_b;
    opnd_t   fn_c;

    // Requester 1 is the candidate when it is alone or when requester 0 went last.
    always_comb begin
        adv          = ~rsp_valid | rsp_ready;
        cand         = req_valid[1] & (~req_valid[0] | ~last);
        req_ready[0] = adv & req_valid[0] & ~cand;
        req_ready[1] = adv & req_valid[1] & cand;
        hs           = |req_ready;
        sel_a        = cand ? req_a1 : req_a0;
        sel_b        = cand ? req_b1 : req_b0;
    end

    fn2_unit u_fn2 (
        .a (sel_a),
        .b (sel_b),
        .c (fn_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_c     <= RST_C;
            rsp_id    <= 1'b0;
            last      <= RST_LAST;
        end else if (hs) begin
            rsp_valid <= 1'b1;
            rsp_c     <= fn_c;
            rsp_id    <= cand;
            last      <= cand;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef OP2ARB_STATS_EN
    // Saturating counters: stop at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (req_ready[0] && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + 1'b1;
            if (req_ready[1] && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_op2_arbiter.sv
// Self-checking bench for op2_arbiter: directed steps then randomized traffic against a behavioural model.
module tb_op2_arbiter;
    localparam int TB_CNT_W = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req_valid = '0;
    logic [1:0] req_ready;
    logic [1:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [1:0] rsp_c;
    logic       rsp_id;
`ifdef OP2ARB_STATS_EN
    logic [TB_CNT_W-1:0] grant_cnt0, grant_cnt1;
`endif

    op2_arbiter #(.CNT_W(TB_CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_c     (rsp_c),
        .rsp_id    (rsp_id)
`ifdef OP2ARB_STATS_EN
       ,.grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model state
    int         m_valid, m_c, m_id, m_last, m_cnt0, m_cnt1;
    logic [1:0] m_rdy;

    function automatic int fn2_ref(int a, int b);
        int p, q, r, s, hi, lo;
        p  = a / 2;  q = a % 2;
        r  = b / 2;  s = b % 2;
        hi = ((1 - p) * r * s + (1 - p) * q * r + p * (1 - r)) > 0 ? 1 : 0;
        lo = ((p + q + s) > 0 && (q + r) > 0 && ((1 - p) + r) > 0) ? 1 : 0;
        return 2 * hi + lo;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_c = 0; m_id = 0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] a0, input logic [1:0] b0,
                         input logic [1:0] a1, input logic [1:0] b1, input logic rr);
        req_valid = v; req_a0 = a0; req_b0 = b0; req_a1 = a1; req_b1 = b1; rsp_ready = rr;
    endtask

    // One clock: check ready, advance model, clock, check registered outputs.
    task automatic cycle(input string tag);
        int w, maxc;
        #1;
        w = -1;
        if (!(m_valid == 1 && rsp_ready == 1'b0)) begin
            if (req_valid == 2'b11)      w = 1 - m_last;
            else if (req_valid == 2'b01) w = 0;
            else if (req_valid == 2'b10) w = 1;
        end
        m_rdy = 2'b00;
        if (w >= 0) m_rdy[w] = 1'b1;
        chk({tag, ".rdy"}, 8'(req_ready), 8'(m_rdy));
        maxc = (1 << TB_CNT_W) - 1;
        if (w >= 0) begin
            m_c     = (w == 0) ? fn2_ref(int'(req_a0), int'(req_b0)) : fn2_ref(int'(req_a1), int'(req_b1));
            m_id    = w;
            m_valid = 1;
            m_last  = w;
            if (w == 0 && m_cnt0 < maxc) m_cnt0++;
            if (w == 1 && m_cnt1 < maxc) m_cnt1++;
        end else if (rsp_ready) begin
            m_valid = 0;
        end
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".vld"}, 8'(rsp_valid), 8'(m_valid));
        chk({tag, ".c"},   8'(rsp_c),     8'(m_c));
        chk({tag, ".id"},  8'(rsp_id),    8'(m_id));
`ifdef OP2ARB_STATS_EN
        chk({tag, ".cnt0"}, 8'(grant_cnt0), 8'(m_cnt0));
        chk({tag, ".cnt1"}, 8'(grant_cnt1), 8'(m_cnt1));
`endif
    endtask

    initial begin
        logic [1:0] va, vb;
        logic [1:0] v;
        model_reset();

        // Reset state
        #12;
        chk("rst.vld", 8'(rsp_valid), 8'h0);
        chk("rst.c",   8'(rsp_c),     8'h0);
        chk("rst.id",  8'(rsp_id),    8'h0);
        chk("rst.rdy", 8'(req_ready), 8'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single requester 0
        drive(2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 1'b1);
        cycle("single");
        chk("single.c_lit",  8'(rsp_c),  8'h2);
        chk("single.id_lit", 8'(rsp_id), 8'h0);
        drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
        cycle("idle");

        // Contention after reset: r0 first, then alternation
        rst_n = 1'b0; #1; model_reset(); @(negedge clk); rst_n = 1'b1;
        drive(2'b11, 2'b01, 2'b11, 2'b11, 2'b10, 1'b1);
        cycle("cont0");
        chk("cont0.c_lit",  8'(rsp_c),  8'h3);
        chk("cont0.id_lit", 8'(rsp_id), 8'h0);
        cycle("cont1");
        chk("cont1.c_lit",  8'(rsp_c),  8'h1);
        chk("cont1.id_lit", 8'(rsp_id), 8'h1);
        for (int i = 0; i < 4; i++) cycle("alt");

        // Stall for 3 cycles with both valid
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle("stall");
            chk("stall.rdy_lit", 8'(req_ready), 8'h0);
        end
        rsp_ready = 1'b1;
        cycle("release");
        chk("release.id_lit", 8'(rsp_id), 8'h0);

        // Exhaustive function check through requester 1
        for (int i = 0; i < 16; i++) begin
            va = 2'(i / 4);
            vb = 2'(i % 4);
            drive(2'b10, 2'b00, 2'b00, va, vb, 1'b1);
            cycle("fn2");
            if (va == 2'b00 && vb == 2'b01) chk("fn2.a00b01", 8'(rsp_c), 8'h0);
        end

        // Mid-operation reset with a response pending
        drive(2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0);
        cycle("pre_rst");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst.vld", 8'(rsp_valid), 8'h0);
        chk("midrst.c",   8'(rsp_c),     8'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(2'b11, 2'b01, 2'b11, 2'b11, 2'b10, 1'b1);
        cycle("post_rst");
        chk("post_rst.id_lit", 8'(rsp_id), 8'h0);

`ifdef OP2ARB_STATS_EN
        // Counter saturation: five grants to requester 0
        rst_n = 1'b0; #1; model_reset(); @(negedge clk); rst_n = 1'b1;
        drive(2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 1'b1);
        for (int i = 0; i < 5; i++) cycle("sat");
        chk("sat.cnt0_lit", 8'(grant_cnt0), 8'h3);
        chk("sat.cnt1_lit", 8'(grant_cnt1), 8'h0);
`endif

        // Randomized traffic, requesters hold valid/operands until accepted
        drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
        m_rdy = 2'b00;
        for (int i = 0; i < 400; i++) begin
            v = req_valid;
            if (!(req_valid[0] && !m_rdy[0]) ) begin
                v[0]   = 1'($urandom_range(0, 1));
                req_a0 = 2'($urandom_range(0, 3));
                req_b0 = 2'($urandom_range(0, 3));
            end
            if (!(req_valid[1] && !m_rdy[1]) ) begin
                v[1]   = 1'($urandom_range(0, 1));
                req_a1 = 2'($urandom_range(0, 3));
                req_b1 = 2'($urandom_range(0, 3));
            end
            req_valid = v;
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
